// File: rtl/uart_stream_rx.sv
// 8N1 UART receiver that assembles NUM_BYTES consecutive bytes, little-endian,
// into one wide word, with framing-error recovery and an inter-byte timeout.
module uart_stream_rx #(
  parameter int unsigned CLK_FREQ     = 50_000_000,
  parameter int unsigned BAUD         = 115200,
  parameter int unsigned NUM_BYTES    = 64,
  parameter int unsigned TIMEOUT_BITS = 32
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               uart_rx,
  output logic [NUM_BYTES*8-1:0]             data_out,
  output logic                               valid,
  output logic                               busy,
  output logic [$clog2(NUM_BYTES+1)-1:0]     byte_cnt,
  output logic                               frame_err,
  output logic                               timeout_err
);
  localparam int unsigned CPB     = CLK_FREQ / BAUD;
  localparam int unsigned HALF    = CPB / 2;
  localparam int unsigned CNT_W   = $clog2(CPB + 1);
  localparam int unsigned IDX_W   = $clog2(NUM_BYTES + 1);
  localparam int unsigned TMO_CYC = TIMEOUT_BITS * CPB;
  localparam int unsigned TMO_W   = $clog2(TMO_CYC + 1);
  localparam int unsigned W       = NUM_BYTES * 8;

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_RECOVER} state_e;

  state_e           state_q, state_d;
  logic             rx_meta_q, rx_s_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [W-1:0]     wbuf_q, wbuf_d;
  logic [W-1:0]     data_q, data_d;
  logic [TMO_W-1:0] idle_q, idle_d;
  logic             valid_q, valid_d;
  logic             ferr_q, ferr_d;
  logic             terr_q, terr_d;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    idx_d     = idx_q;
    wbuf_d    = wbuf_q;
    data_d    = data_q;
    idle_d    = '0;
    valid_d   = 1'b0;
    ferr_d    = 1'b0;
    terr_d    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (!rx_s_q) begin
          state_d = S_START;
          cnt_d   = '0;
        end
      end
      S_START: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(HALF - 1)) begin
          cnt_d     = '0;
          bit_idx_d = '0;
          state_d   = rx_s_q ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(CPB - 1)) begin
          cnt_d     = '0;
          shift_d   = {rx_s_q, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 1'b1;
          if (bit_idx_q == 3'd7) state_d = S_STOP;
        end
      end
      S_STOP: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(CPB - 1)) begin
          cnt_d = '0;
          if (rx_s_q) begin
            state_d = S_IDLE;
            for (int unsigned k = 0; k < NUM_BYTES; k++) begin
              if (idx_q == IDX_W'(k)) wbuf_d[8*k +: 8] = shift_q;
            end
            if (idx_q == IDX_W'(NUM_BYTES - 1)) begin
              data_d  = wbuf_d;
              valid_d = 1'b1;
              idx_d   = '0;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end else begin
            state_d = S_RECOVER;
            ferr_d  = 1'b1;
            idx_d   = '0;
            wbuf_d  = '0;
          end
        end
      end
      S_RECOVER: begin
        if (rx_s_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Idle counter only runs while parked in IDLE with a partial word; any start edge resets it.
    if (state_q == S_IDLE && state_d == S_IDLE && idx_q != '0) begin
      if (idle_q == TMO_W'(TMO_CYC - 1)) begin
        terr_d = 1'b1;
        idx_d  = '0;
        wbuf_d = '0;
      end else begin
        idle_d = idle_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      idx_q     <= '0;
      wbuf_q    <= '0;
      data_q    <= '0;
      idle_q    <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
      terr_q    <= 1'b0;
    end else begin
      rx_meta_q <= uart_rx;
      rx_s_q    <= rx_meta_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      idx_q     <= idx_d;
      wbuf_q    <= wbuf_d;
      data_q    <= data_d;
      idle_q    <= idle_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
      terr_q    <= terr_d;
    end
  end

  assign data_out    = data_q;
  assign valid       = valid_q;
  assign busy        = (state_q != S_IDLE) || (idx_q != '0);
  assign byte_cnt    = idx_q;
  assign frame_err   = ferr_q;
  assign timeout_err = terr_q;

endmodule
